// File: rtl/neuron_lut_scheduler.sv
// Time-multiplexed LUT-neuron layer: runtime-loadable connectivity and truth-table RAMs,
// one neuron per cycle. Optional perf counters enabled by defining NEURON_SCHED_PERF_EN.
module neuron_lut_scheduler #(
    parameter int NUM_NEURONS = 128,
    parameter int IN_ELEMS    = 128,
    parameter int FANIN       = 4,
    parameter int BITS_IN     = 2,
    parameter int BITS_OUT    = 2,
    localparam int NIDX_W     = $clog2(NUM_NEURONS),
    localparam int EIDX_W     = $clog2(IN_ELEMS),
    localparam int LUT_AW     = FANIN * BITS_IN
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [IN_ELEMS*BITS_IN-1:0]     in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_NEURONS*BITS_OUT-1:0] out_data,
    input  logic                            lut_we,
    input  logic [NIDX_W+LUT_AW-1:0]        lut_waddr,
    input  logic [BITS_OUT-1:0]             lut_wdata,
    input  logic                            conn_we,
    input  logic [NIDX_W-1:0]               conn_waddr,
    input  logic [FANIN*EIDX_W-1:0]         conn_wdata,
    output logic                            cfg_drop,
    output logic [31:0]                     perf_frames,
    output logic [31:0]                     perf_stalls
);

    localparam int LUT_DEPTH = NUM_NEURONS << LUT_AW;
    localparam int CNT_W     = $clog2(NUM_NEURONS + 2);
    localparam logic [CNT_W-1:0] ISSUE_END = CNT_W'(NUM_NEURONS);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_NEURONS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                      state;
    state_t                      next_state;
    logic [CNT_W-1:0]            run_cnt;
    logic [IN_ELEMS*BITS_IN-1:0] frame;

    logic [FANIN*EIDX_W-1:0]     conn_mem [NUM_NEURONS];
    logic [BITS_OUT-1:0]         lut_mem  [LUT_DEPTH];

    logic [FANIN*EIDX_W-1:0]     conn_q;
    logic [NIDX_W-1:0]           s1_idx;
    logic [NIDX_W-1:0]           s2_idx;
    logic                        s1_valid;
    logic                        s2_valid;
    logic [LUT_AW-1:0]           lut_addr;
    logic [BITS_OUT-1:0]         lut_q;
    logic [BITS_IN-1:0]          elem [IN_ELEMS];
    logic [EIDX_W-1:0]           src  [FANIN];

    logic                        cfg_open;
    logic                        accept;
    logic                        done_hs;

    assign cfg_open = (state == IDLE);
    assign in_ready = cfg_open;
    assign accept   = in_valid && in_ready;
    assign done_hs  = out_valid && out_ready;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)              next_state = RUN;
            RUN:     if (run_cnt == LAST_CNT) next_state = DONE;
            DONE:    if (done_hs)             next_state = IDLE;
            default:                          next_state = IDLE;
        endcase
    end

    always_comb begin
        for (int e = 0; e < IN_ELEMS; e++) elem[e] = frame[e*BITS_IN +: BITS_IN];
        for (int k = 0; k < FANIN; k++)    src[k]  = conn_q[k*EIDX_W +: EIDX_W];
    end

    // Out-of-range source indices leave their address field at zero.
    always_comb begin
        lut_addr = '0;
        for (int k = 0; k < FANIN; k++) begin
            if (32'(src[k]) < IN_ELEMS) lut_addr[k*BITS_IN +: BITS_IN] = elem[src[k]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            run_cnt   <= '0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            cfg_drop  <= 1'b0;
        end else begin
            state    <= next_state;
            run_cnt  <= (state == RUN) ? run_cnt + 1'b1 : '0;
            s1_valid <= (state == RUN) && (run_cnt < ISSUE_END);
            s2_valid <= s1_valid;
            cfg_drop <= (lut_we || conn_we) && !cfg_open;
            if (done_hs)
                out_valid <= 1'b0;
            else if (state == DONE)
                out_valid <= 1'b1;
            if (s2_valid) begin
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    if (s2_idx == NIDX_W'(n)) out_data[n*BITS_OUT +: BITS_OUT] <= lut_q;
                end
            end
        end
    end

    // Storage and pipeline data carry no reset so the RAMs map onto block memory.
    always_ff @(posedge clk) begin
        if (accept) frame <= in_data;
        if (conn_we && cfg_open && (32'(conn_waddr) < NUM_NEURONS))
            conn_mem[conn_waddr] <= conn_wdata;
        if (lut_we && cfg_open && (32'(lut_waddr) < LUT_DEPTH))
            lut_mem[lut_waddr] <= lut_wdata;
        conn_q <= conn_mem[run_cnt[NIDX_W-1:0]];
        s1_idx <= run_cnt[NIDX_W-1:0];
        lut_q  <= lut_mem[{s1_idx, lut_addr}];
        s2_idx <= s1_idx;
    end

`ifdef NEURON_SCHED_PERF_EN
    logic [31:0] frames_q;
    logic [31:0] stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_q <= '0;
            stalls_q <= '0;
        end else begin
            if (done_hs)                frames_q <= frames_q + 32'd1;
            if (out_valid && !out_ready) stalls_q <= stalls_q + 32'd1;
        end
    end

    assign perf_frames = frames_q;
    assign perf_stalls = stalls_q;
`else
    assign perf_frames = '0;
    assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_neuron_lut_scheduler.sv
// Directed bench for neuron_lut_scheduler; IN_ELEMS=100 so that connectivity indices
// beyond the vector (e.g. 120) are representable and can be exercised.
module tb_neuron_lut_scheduler;

    localparam int NN = 128;
    localparam int IE = 100;
    localparam int FI = 4;
    localparam int BI = 2;
    localparam int BO = 2;
    localparam int NW = 7;
    localparam int EW = 7;
    localparam int AW = 8;
    localparam int LATENCY = NN + 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IE*BI-1:0]  in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [NN*BO-1:0]  out_data;
    logic              lut_we = 1'b0;
    logic [NW+AW-1:0]  lut_waddr = '0;
    logic [BO-1:0]     lut_wdata = '0;
    logic              conn_we = 1'b0;
    logic [NW-1:0]     conn_waddr = '0;
    logic [FI*EW-1:0]  conn_wdata = '0;
    logic              cfg_drop;
    logic [31:0]       perf_frames;
    logic [31:0]       perf_stalls;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] e0, e1, e2, e3;
        logic [1:0] exp0, exp5, exp127;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    neuron_lut_scheduler #(
        .NUM_NEURONS(NN), .IN_ELEMS(IE), .FANIN(FI), .BITS_IN(BI), .BITS_OUT(BO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .conn_we(conn_we), .conn_waddr(conn_waddr), .conn_wdata(conn_wdata),
        .cfg_drop(cfg_drop), .perf_frames(perf_frames), .perf_stalls(perf_stalls)
    );

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lutWrite(input int n, input int a, input logic [1:0] d);
        lut_we    = 1'b1;
        lut_waddr = {NW'(n), AW'(a)};
        lut_wdata = d;
        tick();
        lut_we    = 1'b0;
    endtask

    task automatic connWrite(input int n, input int k0, input int k1, input int k2, input int k3);
        conn_we    = 1'b1;
        conn_waddr = NW'(n);
        conn_wdata = {EW'(k3), EW'(k2), EW'(k1), EW'(k0)};
        tick();
        conn_we    = 1'b0;
    endtask

    function automatic logic [IE*BI-1:0] makeFrame(input vec_t v);
        logic [IE*BI-1:0] f;
        f = '0;
        f[1:0] = v.e0;
        f[3:2] = v.e1;
        f[5:4] = v.e2;
        f[7:6] = v.e3;
        return f;
    endfunction

    function automatic logic [NN*BO-1:0] expVec(input logic [1:0] s0, input logic [1:0] s5, input logic [1:0] s127);
        logic [NN*BO-1:0] r;
        r = '0;
        r[1:0]     = s0;
        r[11:10]   = s5;
        r[255:254] = s127;
        return r;
    endfunction

    task automatic startFrame(input logic [IE*BI-1:0] f);
        in_data  = f;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        while (!out_valid && lat < 400) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic applyStimulus(input vec_t v, output int lat);
        startFrame(makeFrame(v));
        waitValid(lat);
    endtask

    task automatic finishFrame();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int seen;
        logic [31:0] stalls0;
        logic [31:0] frames0;
        logic [1:0] v5;
        logic [AW-1:0] a;

        //            e0     e1     e2     e3     n0     n5     n127
        vecs[0] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        vecs[1] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        vecs[2] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1};
        vecs[3] = '{2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2};
        vecs[4] = '{2'd3, 2'd0, 2'd3, 2'd2, 2'd0, 2'd3, 2'd3};
        vecs[5] = '{2'd0, 2'd3, 2'd1, 2'd1, 2'd0, 2'd3, 2'd0};
        vecs[6] = '{2'd2, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd2};

        #2;
        checkOutput("reset_in_ready", 256'(in_ready), 256'(1'b1));
        checkOutput("reset_out_valid", 256'(out_valid), 256'(1'b0));
        checkOutput("reset_out_data", 256'(out_data), 256'(0));
        checkOutput("reset_cfg_drop", 256'(cfg_drop), 256'(1'b0));
        checkOutput("reset_perf_frames", 256'(perf_frames), 256'(0));
        #10 rst_n = 1'b1;
        tick();

        // Neuron 5 mixes an out-of-range source (120) with in-range ones; neuron 127 checks the last slot.
        for (int n = 0; n < NN; n++) begin
            if (n == 0)        connWrite(n, 0, 1, 2, 3);
            else if (n == 5)   connWrite(n, 2, 3, 120, 1);
            else if (n == 127) connWrite(n, 0, 0, 0, 0);
            else               connWrite(n, 120, 120, 120, 120);
        end
        for (int n = 1; n < NN - 1; n++) if (n != 5) lutWrite(n, 0, 2'd0);
        for (int i = 0; i < 256; i++) begin
            a  = AW'(i);
            v5 = a[7:6] - a[1:0] + a[3:2] + {a[4], 1'b0};
            lutWrite(0, i, (i == 8'h06) ? 2'd1 : 2'd0);
            lutWrite(5, i, v5);
            lutWrite(127, i, a[1:0]);
        end
        checkOutput("idle_write_no_drop", 256'(cfg_drop), 256'(1'b0));

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], lat);
            checkOutput($sformatf("latency_v%0d", i), 256'(lat), 256'(LATENCY));
            checkOutput($sformatf("data_v%0d", i), 256'(out_data),
                        256'(expVec(vecs[i].exp0, vecs[i].exp5, vecs[i].exp127)));
            finishFrame();
            checkOutput($sformatf("idle_after_v%0d", i), 256'({in_ready, out_valid}), 256'(2'b10));
        end

        // Backpressure: result held, new vectors refused.
        applyStimulus(vecs[0], lat);
        stalls0 = perf_stalls;
        frames0 = perf_frames;
        in_data = makeFrame(vecs[4]);
        in_valid = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_data !== expVec(2'd1, 2'd1, 2'd2) || in_ready !== 1'b0 || out_valid !== 1'b1) seen++;
        end
        in_valid = 1'b0;
        checkOutput("backpressure_hold", 256'(seen), 256'(0));
`ifdef NEURON_SCHED_PERF_EN
        checkOutput("perf_stalls_delta", 256'(perf_stalls - stalls0), 256'(10));
`else
        checkOutput("perf_stalls_tied", 256'(perf_stalls), 256'(0));
`endif
        finishFrame();
        checkOutput("bp_release_idle", 256'({in_ready, out_valid}), 256'(2'b10));
`ifdef NEURON_SCHED_PERF_EN
        checkOutput("perf_frames_delta", 256'(perf_frames - frames0), 256'(1));
`else
        checkOutput("perf_frames_tied", 256'(perf_frames), 256'(0));
`endif

        // Config writes while busy must be dropped.
        startFrame(makeFrame(vecs[0]));
        repeat (5) tick();
        lut_we = 1'b1;  lut_waddr = {NW'(0), 8'h06}; lut_wdata = 2'd3;
        conn_we = 1'b1; conn_waddr = '0; conn_wdata = {4{EW'(120)}};
        tick();
        lut_we = 1'b0;
        conn_we = 1'b0;
        checkOutput("cfg_drop_pulse", 256'(cfg_drop), 256'(1'b1));
        tick();
        checkOutput("cfg_drop_clear", 256'(cfg_drop), 256'(1'b0));
        waitValid(lat);
        checkOutput("run_write_ignored", 256'(out_data), 256'(expVec(2'd1, 2'd1, 2'd2)));
        finishFrame();
        applyStimulus(vecs[0], lat);
        checkOutput("rerun_identical", 256'(out_data), 256'(expVec(2'd1, 2'd1, 2'd2)));
        finishFrame();

        // Abort mid-RUN via asynchronous reset.
        startFrame(makeFrame(vecs[4]));
        repeat (50) tick();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_async_regs", 256'({in_ready, out_valid}), 256'(2'b10));
        checkOutput("abort_out_data", 256'(out_data), 256'(0));
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (150) begin
            tick();
            if (out_valid) seen++;
        end
        checkOutput("abort_no_valid", 256'(seen), 256'(0));
        applyStimulus(vecs[0], lat);
        checkOutput("resubmit_latency", 256'(lat), 256'(LATENCY));
        checkOutput("resubmit_data", 256'(out_data), 256'(expVec(2'd1, 2'd1, 2'd2)));
        finishFrame();

        // A config write in the accept cycle lands before the frame reads it.
        in_data = makeFrame(vecs[0]);
        in_valid = 1'b1;
        lut_we = 1'b1; lut_waddr = {NW'(127), 8'hAA}; lut_wdata = 2'd1;
        tick();
        in_valid = 1'b0;
        lut_we = 1'b0;
        waitValid(lat);
        checkOutput("write_with_accept", 256'(out_data), 256'(expVec(2'd1, 2'd1, 2'd1)));
        finishFrame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
